// File: rtl/cache_bus_arbiter.sv
// Round-robin arbiter funnelling several cache bus ports onto a single
// memory port, with at most one memory transaction in flight.
module cache_bus_arbiter #(
    parameter int num_caches_p     = 4,
    parameter int dma_data_width_p = 4
) (
    input  logic                                          clk_i,
    input  logic                                          nreset_i,
    input  logic [num_caches_p-1:0]                       cb_valid_i,
    input  logic [num_caches_p-1:0][32*dma_data_width_p+32:0] cb_pkt_i,
    output logic [num_caches_p-1:0]                       cb_yumi_o,
    output logic [num_caches_p-1:0]                       cb_valid_o,
    output logic [32*dma_data_width_p-1:0]                cb_data_o,
    output logic                                          mem_valid_o,
    input  logic                                          mem_ready_i,
    output logic [32*dma_data_width_p+32:0]               mem_pkt_o,
    input  logic                                          mem_valid_i,
    input  logic [32*dma_data_width_p-1:0]                mem_data_i,
    output logic                                          err_o
);

    localparam int idx_w_lp = $clog2(num_caches_p);

    typedef struct packed {
        logic                              we;
        logic [31:0]                       addr;
        logic [32*dma_data_width_p-1:0]    wdata;
    } cache_bus_pkt_t;

    typedef enum logic [1:0] {
        s_idle,
        s_req,
        s_resp
    } state_e;

    state_e                state_r;
    logic [idx_w_lp-1:0]   grant_r;
    logic [idx_w_lp-1:0]   rr_ptr_r;
    cache_bus_pkt_t        pkt_r;
    logic                  err_r;

    logic                  pick_valid;
    logic [idx_w_lp-1:0]   pick_idx;
    logic                  accept;
    logic                  respond;
    logic                  proto_err;

    // Scan from the highest offset down so the nearest requester
    // after rr_ptr_r is the last one written and therefore wins.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        for (int i = num_caches_p - 1; i >= 0; i--) begin
            if (cb_valid_i[rr_ptr_r + idx_w_lp'(i)]) begin
                pick_valid = 1'b1;
                pick_idx   = rr_ptr_r + idx_w_lp'(i);
            end
        end
    end

    assign accept  = (state_r == s_req) && mem_ready_i;
    assign respond = (state_r == s_resp) && mem_valid_i;

    assign proto_err =
        ((state_r == s_req) && !cb_valid_i[grant_r]) ||
        (mem_valid_i && (state_r != s_resp));

    always_ff @(posedge clk_i or negedge nreset_i) begin
        if (!nreset_i) begin
            state_r  <= s_idle;
            grant_r  <= '0;
            rr_ptr_r <= '0;
            pkt_r    <= '0;
            err_r    <= 1'b0;
        end else begin
            if (proto_err)
                err_r <= 1'b1;
            unique case (state_r)
                s_idle: begin
                    if (pick_valid) begin
                        grant_r <= pick_idx;
                        pkt_r   <= cb_pkt_i[pick_idx];
                        state_r <= s_req;
                    end
                end
                s_req: begin
                    if (mem_ready_i) begin
                        rr_ptr_r <= grant_r + 1'b1;
                        state_r  <= pkt_r.we ? s_idle : s_resp;
                    end
                end
                s_resp: begin
                    if (mem_valid_i)
                        state_r <= s_idle;
                end
                default: state_r <= s_idle;
            endcase
        end
    end

    always_comb begin
        cb_yumi_o           = '0;
        cb_yumi_o[grant_r]  = accept;
        cb_valid_o          = '0;
        cb_valid_o[grant_r] = respond;
    end

    assign cb_data_o   = mem_data_i;
    assign mem_valid_o = (state_r == s_req);
    assign mem_pkt_o   = pkt_r;
    assign err_o       = err_r;

endmodule

// File: tb/tb_cache_bus_arbiter.sv
// Directed testbench for cache_bus_arbiter.
// Each task drives one scenario and checks the outputs inline.
module tb_cache_bus_arbiter;

    localparam int NC = 4;
    localparam int DW = 128;
    localparam int PW = DW + 33;

    logic                   clk_i = 1'b0;
    logic                   nreset_i = 1'b1;
    logic [NC-1:0]          cb_valid_i = '0;
    logic [NC-1:0][PW-1:0]  cb_pkt_i = '0;
    logic [NC-1:0]          cb_yumi_o;
    logic [NC-1:0]          cb_valid_o;
    logic [DW-1:0]          cb_data_o;
    logic                   mem_valid_o;
    logic                   mem_ready_i = 1'b0;
    logic [PW-1:0]          mem_pkt_o;
    logic                   mem_valid_i = 1'b0;
    logic [DW-1:0]          mem_data_i = '0;
    logic                   err_o;

    int tests = 0;
    int fails = 0;

    cache_bus_arbiter #(
        .num_caches_p     (NC),
        .dma_data_width_p (4)
    ) dut (
        .clk_i       (clk_i),
        .nreset_i    (nreset_i),
        .cb_valid_i  (cb_valid_i),
        .cb_pkt_i    (cb_pkt_i),
        .cb_yumi_o   (cb_yumi_o),
        .cb_valid_o  (cb_valid_o),
        .cb_data_o   (cb_data_o),
        .mem_valid_o (mem_valid_o),
        .mem_ready_i (mem_ready_i),
        .mem_pkt_o   (mem_pkt_o),
        .mem_valid_i (mem_valid_i),
        .mem_data_i  (mem_data_i),
        .err_o       (err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        cb_valid_i  = '0;
        cb_pkt_i    = '0;
        mem_ready_i = 1'b0;
        mem_valid_i = 1'b0;
        mem_data_i  = '0;
        #2 nreset_i = 1'b0;
        repeat (2) @(posedge clk_i);
        #2 nreset_i = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        #1 nreset_i = 1'b0;
        #2;
        tests++;
        if ({mem_valid_o, cb_yumi_o, cb_valid_o, err_o} !== 10'b0) begin
            fails++;
            $display("FAIL reset_outputs: got mv=%b y=%b v=%b e=%b exp all 0",
                     mem_valid_o, cb_yumi_o, cb_valid_o, err_o);
        end
        tests++;
        if (dut.rr_ptr_r !== 2'd0) begin
            fails++;
            $display("FAIL reset_rr_ptr: got %0d exp 0", dut.rr_ptr_r);
        end
        @(posedge clk_i);
        #2 nreset_i = 1'b1;
        tick();
        tests++;
        if (mem_valid_o !== 1'b0 || err_o !== 1'b0) begin
            fails++;
            $display("FAIL reset_release: got mv=%b e=%b exp 0 0",
                     mem_valid_o, err_o);
        end
    endtask

    task automatic test_single_read();
        logic [PW-1:0] exp_pkt;
        logic [DW-1:0] rdata;
        do_reset();
        exp_pkt = {1'b0, 32'h0000_0100, 128'h0};
        rdata   = {4{32'hA5A5_A5A5}};
        cb_valid_i  = 4'b0100;
        cb_pkt_i[2] = exp_pkt;
        #1;
        tests++;
        if (mem_valid_o !== 1'b0) begin
            fails++;
            $display("FAIL rd_idle_mv: got %b exp 0", mem_valid_o);
        end
        tick();
        #1;
        tests++;
        if (mem_valid_o !== 1'b1 || mem_pkt_o !== exp_pkt ||
            cb_yumi_o !== 4'b0000) begin
            fails++;
            $display("FAIL rd_req: got mv=%b pkt=%h y=%b exp 1 %h 0000",
                     mem_valid_o, mem_pkt_o, cb_yumi_o, exp_pkt);
        end
        tick();
        mem_ready_i = 1'b1;
        #1;
        tests++;
        if (cb_yumi_o !== 4'b0100) begin
            fails++;
            $display("FAIL rd_yumi: got %b exp 0100", cb_yumi_o);
        end
        tick();
        cb_valid_i  = '0;
        mem_ready_i = 1'b0;
        tick();
        tick();
        mem_valid_i = 1'b1;
        mem_data_i  = rdata;
        #1;
        tests++;
        if (cb_valid_o !== 4'b0100 || cb_data_o !== rdata) begin
            fails++;
            $display("FAIL rd_resp: got v=%b d=%h exp 0100 %h",
                     cb_valid_o, cb_data_o, rdata);
        end
        tests++;
        if (dut.rr_ptr_r !== 2'd3) begin
            fails++;
            $display("FAIL rd_rr_ptr: got %0d exp 3", dut.rr_ptr_r);
        end
        tick();
        mem_valid_i = 1'b0;
        #1;
        tests++;
        if (err_o !== 1'b0 || mem_valid_o !== 1'b0 || cb_valid_o !== 4'b0) begin
            fails++;
            $display("FAIL rd_done: got e=%b mv=%b v=%b exp 0 0 0000",
                     err_o, mem_valid_o, cb_valid_o);
        end
    endtask

    task automatic test_round_robin();
        int order [5] = '{0, 1, 2, 3, 0};
        int lat;
        int k;
        int g;
        logic [NC-1:0] prev_y;
        do_reset();
        lat = 0;
        k = 0;
        g = 0;
        prev_y = '0;
        for (int i = 0; i < NC; i++)
            cb_pkt_i[i] = {1'b0, 32'(i * 16), 128'h0};
        cb_valid_i  = 4'b1111;
        mem_ready_i = 1'b1;
        for (int c = 0; c < 80 && k < 5; c++) begin
            mem_valid_i = (lat == 1);
            mem_data_i  = {4{32'(c)}};
            if (lat > 0)
                lat--;
            #1;
            if (mem_valid_i) begin
                tests++;
                if (cb_valid_o !== (4'b0001 << g)) begin
                    fails++;
                    $display("FAIL rr_resp: got %b exp %b",
                             cb_valid_o, 4'b0001 << g);
                end
            end
            if (cb_yumi_o !== 4'b0000) begin
                tests++;
                if (cb_yumi_o !== (4'b0001 << order[k]) ||
                    prev_y !== 4'b0000) begin
                    fails++;
                    $display("FAIL rr_grant%0d: got %b prev %b exp %b",
                             k, cb_yumi_o, prev_y, 4'b0001 << order[k]);
                end
                g = order[k];
                k++;
                lat = 3;
            end
            prev_y = cb_yumi_o;
            tick();
        end
        mem_valid_i = 1'b0;
        tests++;
        if (k != 5) begin
            fails++;
            $display("FAIL rr_timeout: got %0d grants exp 5", k);
        end
    endtask

    task automatic test_write();
        logic [PW-1:0] exp_pkt;
        do_reset();
        exp_pkt = {1'b1, 32'h0000_0040,
                   128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D};
        cb_valid_i  = 4'b0010;
        cb_pkt_i[1] = exp_pkt;
        tick();
        for (int i = 0; i < 4; i++) begin
            #1;
            tests++;
            if (mem_valid_o !== 1'b1 || mem_pkt_o !== exp_pkt ||
                cb_yumi_o !== 4'b0000) begin
                fails++;
                $display("FAIL wr_hold%0d: got mv=%b pkt=%h y=%b",
                         i, mem_valid_o, mem_pkt_o, cb_yumi_o);
            end
            tick();
        end
        mem_ready_i = 1'b1;
        #1;
        tests++;
        if (mem_pkt_o !== exp_pkt || cb_yumi_o !== 4'b0010) begin
            fails++;
            $display("FAIL wr_accept: got pkt=%h y=%b exp %h 0010",
                     mem_pkt_o, cb_yumi_o, exp_pkt);
        end
        tick();
        cb_valid_i  = '0;
        mem_ready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            tests++;
            if (mem_valid_o !== 1'b0 || cb_valid_o !== 4'b0 ||
                cb_yumi_o !== 4'b0) begin
                fails++;
                $display("FAIL wr_after%0d: got mv=%b v=%b y=%b exp 0",
                         i, mem_valid_o, cb_valid_o, cb_yumi_o);
            end
            tick();
        end
        tests++;
        if (dut.rr_ptr_r !== 2'd2 || err_o !== 1'b0) begin
            fails++;
            $display("FAIL wr_state: got rr=%0d e=%b exp 2 0",
                     dut.rr_ptr_r, err_o);
        end
    endtask

    task automatic test_cancel();
        do_reset();
        cb_valid_i  = 4'b0001;
        cb_pkt_i[0] = {1'b0, 32'h0000_0200, 128'h0};
        tick();
        cb_valid_i = 4'b0000;
        #1;
        tests++;
        if (mem_valid_o !== 1'b1 || err_o !== 1'b0) begin
            fails++;
            $display("FAIL cancel_drop: got mv=%b e=%b exp 1 0",
                     mem_valid_o, err_o);
        end
        tick();
        mem_ready_i = 1'b1;
        #1;
        tests++;
        if (err_o !== 1'b1 || mem_valid_o !== 1'b1 ||
            cb_yumi_o !== 4'b0001) begin
            fails++;
            $display("FAIL cancel_err: got e=%b mv=%b y=%b exp 1 1 0001",
                     err_o, mem_valid_o, cb_yumi_o);
        end
        tick();
        mem_ready_i = 1'b0;
    endtask

    task automatic test_stray();
        do_reset();
        mem_valid_i = 1'b1;
        mem_data_i  = {4{32'h1234_5678}};
        #1;
        tests++;
        if (cb_valid_o !== 4'b0000) begin
            fails++;
            $display("FAIL stray_valid: got %b exp 0000", cb_valid_o);
        end
        tick();
        mem_valid_i = 1'b0;
        #1;
        tests++;
        if (err_o !== 1'b1) begin
            fails++;
            $display("FAIL stray_err: got %b exp 1", err_o);
        end
        repeat (3) tick();
        tests++;
        if (err_o !== 1'b1) begin
            fails++;
            $display("FAIL stray_sticky: got %b exp 1", err_o);
        end
        do_reset();
        tests++;
        if (err_o !== 1'b0) begin
            fails++;
            $display("FAIL stray_clear: got %b exp 0", err_o);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        cb_valid_i  = 4'b1000;
        cb_pkt_i[3] = {1'b0, 32'h0000_0300, 128'h0};
        tick();
        mem_ready_i = 1'b1;
        #1;
        tests++;
        if (cb_yumi_o !== 4'b1000) begin
            fails++;
            $display("FAIL mid_yumi: got %b exp 1000", cb_yumi_o);
        end
        tick();
        cb_valid_i  = '0;
        mem_ready_i = 1'b0;
        #2 nreset_i = 1'b0;
        mem_valid_i = 1'b1;
        mem_data_i  = {4{32'h0BAD_0BAD}};
        #1;
        tests++;
        if ({mem_valid_o, cb_yumi_o, cb_valid_o, err_o} !== 10'b0) begin
            fails++;
            $display("FAIL mid_async: got mv=%b y=%b v=%b e=%b exp 0",
                     mem_valid_o, cb_yumi_o, cb_valid_o, err_o);
        end
        tests++;
        if (dut.rr_ptr_r !== 2'd0 || dut.grant_r !== 2'd0) begin
            fails++;
            $display("FAIL mid_regs: got rr=%0d g=%0d exp 0 0",
                     dut.rr_ptr_r, dut.grant_r);
        end
        mem_valid_i = 1'b0;
        @(posedge clk_i);
        #2 nreset_i = 1'b1;
        tick();
        cb_valid_i = 4'b1000;
        tick();
        mem_ready_i = 1'b1;
        #1;
        tests++;
        if (mem_valid_o !== 1'b1 || cb_yumi_o !== 4'b1000) begin
            fails++;
            $display("FAIL mid_rereq: got mv=%b y=%b exp 1 1000",
                     mem_valid_o, cb_yumi_o);
        end
        tick();
        cb_valid_i  = '0;
        mem_ready_i = 1'b0;
        mem_valid_i = 1'b1;
        mem_data_i  = {4{32'h3333_3333}};
        #1;
        tests++;
        if (cb_valid_o !== 4'b1000 || err_o !== 1'b0) begin
            fails++;
            $display("FAIL mid_resp: got v=%b e=%b exp 1000 0",
                     cb_valid_o, err_o);
        end
        tick();
        mem_valid_i = 1'b0;
    endtask

    task automatic test_back_to_back();
        do_reset();
        cb_valid_i  = 4'b0001;
        cb_pkt_i[0] = {1'b0, 32'h0000_0010, 128'h0};
        cb_pkt_i[1] = {1'b0, 32'h0000_0020, 128'h0};
        tick();
        mem_ready_i = 1'b1;
        #1;
        tests++;
        if (cb_yumi_o !== 4'b0001) begin
            fails++;
            $display("FAIL b2b_yumi0: got %b exp 0001", cb_yumi_o);
        end
        tick();
        cb_valid_i  = '0;
        mem_ready_i = 1'b0;
        tick();
        mem_valid_i = 1'b1;
        mem_data_i  = {4{32'h0F0F_0F0F}};
        cb_valid_i  = 4'b0010;
        mem_ready_i = 1'b1;
        #1;
        tests++;
        if (cb_valid_o !== 4'b0001 || cb_yumi_o !== 4'b0000) begin
            fails++;
            $display("FAIL b2b_resp: got v=%b y=%b exp 0001 0000",
                     cb_valid_o, cb_yumi_o);
        end
        tick();
        mem_valid_i = 1'b0;
        #1;
        tests++;
        if (cb_yumi_o !== 4'b0000 || mem_valid_o !== 1'b0) begin
            fails++;
            $display("FAIL b2b_gap: got y=%b mv=%b exp 0000 0",
                     cb_yumi_o, mem_valid_o);
        end
        tick();
        tests++;
        if (cb_yumi_o !== 4'b0010 || mem_pkt_o !== cb_pkt_i[1]) begin
            fails++;
            $display("FAIL b2b_yumi1: got y=%b pkt=%h exp 0010 %h",
                     cb_yumi_o, mem_pkt_o, cb_pkt_i[1]);
        end
        tick();
        cb_valid_i  = '0;
        mem_ready_i = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_round_robin();
        test_write();
        test_cancel();
        test_stray();
        test_reset_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/cache_bus_arbiter.md
CACHE_BUS_ARBITER -- requirements
Module: cache_bus_arbiter

Interface
REQ-001 The block SHALL take parameter num_caches_p, default 4: number of cache bus ports, power of two, at least 2.
REQ-002 The block SHALL take parameter dma_data_width_p, default 4: bus transfer size in 32-bit words.
REQ-003 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-004 clk_i  input  1  clock; all state updates on posedge.
REQ-005 nreset_i  input  1  asynchronous active-low reset.
REQ-006 cb_valid_i  input  num_caches_p  per-cache request valid.
REQ-007 cb_pkt_i  input  num_caches_p x cache_bus_pkt_t  per-cache request (we, addr, wdata).
REQ-008 cb_yumi_o  output  num_caches_p  per-cache request accepted this cycle.
REQ-009 cb_valid_o  output  num_caches_p  per-cache read data valid, one-cycle pulse.
REQ-010 cb_data_o  output  dma_data_width_p*32  read data, shared by all caches.
REQ-011 mem_valid_o  output  1  request to memory valid.
REQ-012 mem_ready_i  input  1  memory accepts the request this cycle.
REQ-013 mem_pkt_o  output  cache_bus_pkt_t  request to memory.
REQ-014 mem_valid_i  input  1  memory read response valid.
REQ-015 mem_data_i  input  dma_data_width_p*32  memory read data.
REQ-016 err_o  output  1  sticky protocol error flag.

Function
REQ-017 The block SHALL allow at most one outstanding memory transaction.
REQ-018 The block SHALL implement FSM states s_idle, s_req and s_resp.
REQ-019 s_idle: if any cb_valid_i bit is set, grant the first requester at or after rr_ptr_r (cyclic), register the grant index and cb_pkt_i of that cache, then go to s_req; otherwise stay in s_idle.
REQ-020 s_req: mem_valid_o=1 and mem_pkt_o = the registered packet.
REQ-021 s_req, when mem_ready_i=1: cb_yumi_o[grant]=1 for that cycle only; go to s_resp if we=0, or to s_idle if we=1.
REQ-022 s_req, when mem_ready_i=0: hold all outputs and stay in s_req.
REQ-023 s_resp, when mem_valid_i=1: cb_valid_o[grant]=1 and cb_data_o=mem_data_i in that same cycle, then go to s_idle.
REQ-024 cb_data_o SHALL be combinational pass-through of mem_data_i; cb_valid_o SHALL be 0 whenever mem_valid_i=0.
REQ-025 rr_ptr_r SHALL update to (grant+1) mod num_caches_p on the cycle cb_yumi_o fires, and hold at all other times.
REQ-026 The minimum gap between successive grants SHALL be one idle cycle: s_resp/s_req -> s_idle -> s_req.
REQ-027 A new request arriving in the same cycle as a response SHALL NOT be granted until the following s_idle cycle.
REQ-028 Deassertion of cb_valid_i[grant] while in s_req SHALL NOT cancel the transaction; err_o SHALL be set.
REQ-029 mem_valid_i=1 outside s_resp SHALL be ignored (no cb_valid_o) and SHALL set err_o.
REQ-030 At most one bit of cb_yumi_o and at most one bit of cb_valid_o SHALL be set in any cycle.

Reset
REQ-031 Reset assertion SHALL force state=s_idle, rr_ptr_r=0, err_o=0 and grant=0 immediately, without waiting for a clock edge.
REQ-032 During reset, cb_yumi_o, cb_valid_o and mem_valid_o SHALL all be 0.
REQ-033 Reset mid-transaction SHALL abort the transaction with no response; a later mem_valid_i SHALL be treated per REQ-029 only after reset is released.

Verification
REQ-034 Single read: cache 2 valid, addr 0x100, we=0; mem_ready_i=1 at cycle 2; mem_valid_i=1 with data 0xA5.. at cycle 5 -> cb_yumi_o=0100 at cycle 2, cb_valid_o=0100 with data 0xA5.. at cycle 5, rr_ptr_r=3.
REQ-035 All four caches request reads continuously, memory latency 3 -> grant order 0,1,2,3,0, each yumi pulse one cycle, no overlap.
REQ-036 Write: cache 1 we=1, addr 0x40, wdata pattern; mem_ready_i held 0 for 4 cycles, then 1 -> mem_pkt_o stable for 5 cycles, cb_yumi_o=0010 once, then s_idle with no cb_valid_o.
REQ-037 Stray mem_valid_i=1 in s_idle -> cb_valid_o=0000 and err_o=1, sticky until reset.
REQ-038 Reset asserted in s_resp with a cache 3 read outstanding -> outputs 0 asynchronously, rr_ptr_r=0; after release, cache 3 re-request is served normally.
REQ-039 Response and new request in the same cycle (cache 0 response, cache 1 valid) -> cb_valid_o=0001 that cycle, cb_yumi_o=0010 no earlier than two cycles later.
